// File: rtl/bpsk_modulator.sv
// bpsk_modulator
// BPSK bit-to-carrier mapper placed after the sine generator. Words arrive on
// a valid/ready handshake. They are sent MSB-first, one bit per carrier period.
// Each output sample is the generator's sin (bit 1) or neg_sin (bit 0) sample.
// The block also drives the generator enable, so the carrier only runs while
// a frame is being sent.
//
// Optional feature: define BPSK_PREAMBLE_EN to send PREAMBLE before the first
// word of every frame. Back-to-back words do not repeat the preamble.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   data_in       word to transmit (DATA_WIDTH)
//   data_valid    data_in is valid
//   data_ready    combinational ready; a word transfers on data_valid & data_ready
//   sin_in        generator sine sample for phase cnt_in-1
//   neg_sin_in    generator negated sine sample for phase cnt_in-1
//   cnt_in        generator phase counter
//   gen_en        registered generator enable
//   mod_out       registered modulated sample
//   mod_valid     mod_out is valid
//   busy          block is not in IDLE
//
// State | meaning
// IDLE  | generator off, ready for a word
// ALIGN | generator running, waiting for phase 0 to appear on the inputs
// PRE   | sending the preamble (only with BPSK_PREAMBLE_EN)
// TX    | sending the data shift register
module bpsk_modulator #(
  parameter int                    SAMPLE_NUMBER = 256,
  parameter int                    SAMPLE_WIDTH  = 12,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE      = 8'hAA
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_valid,
  output logic                             data_ready,
  input  logic [SAMPLE_WIDTH-1:0]          sin_in,
  input  logic [SAMPLE_WIDTH-1:0]          neg_sin_in,
  input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
  output logic                             gen_en,
  output logic [SAMPLE_WIDTH-1:0]          mod_out,
  output logic                             mod_valid,
  output logic                             busy
);

  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_FIRST = CW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef BPSK_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, PRE = 2'd2, TX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, TX = 2'd3} state_t;
  logic unused_preamble;
  assign unused_preamble = ^PREAMBLE;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BW-1:0]           bit_cnt;
  logic                    gen_en_d;   // generator inputs are valid only when this is set

  logic                    align_hit;
  logic                    last_sample;
  logic                    last_bit;
  logic                    xfer;
  logic                    sample_now;
  logic                    cur_bit;

  always_comb begin
    align_hit   = gen_en_d && (cnt_in == CNT_FIRST);
    last_sample = gen_en_d && (cnt_in == '0);
    last_bit    = (bit_cnt == BIT_LAST);

    data_ready = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    data_ready = 1'b1;
        TX:      data_ready = last_sample && last_bit;
        default: data_ready = 1'b0;
      endcase
    end
    xfer = data_valid && data_ready;

    // The ALIGN hit cycle already carries the first sample of the first bit.
    sample_now = 1'b0;
    cur_bit    = shreg[DATA_WIDTH-1];
    case (state)
      ALIGN: begin
        sample_now = align_hit;
`ifdef BPSK_PREAMBLE_EN
        cur_bit = PREAMBLE[DATA_WIDTH-1];
`endif
      end
`ifdef BPSK_PREAMBLE_EN
      PRE: begin
        sample_now = 1'b1;
        cur_bit    = PREAMBLE[BIT_LAST - bit_cnt];
      end
`endif
      TX:      sample_now = 1'b1;
      default: sample_now = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gen_en    <= 1'b0;
      gen_en_d  <= 1'b0;
      mod_out   <= '0;
      mod_valid <= 1'b0;
    end else begin
      gen_en_d  <= gen_en;
      mod_valid <= sample_now;
      if (sample_now) begin
        mod_out <= cur_bit ? sin_in : neg_sin_in;
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            shreg   <= data_in;
            bit_cnt <= '0;
            gen_en  <= 1'b1;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          if (align_hit) begin
`ifdef BPSK_PREAMBLE_EN
            state <= PRE;
`else
            state <= TX;
`endif
          end
        end
`ifdef BPSK_PREAMBLE_EN
        PRE: begin
          if (last_sample) begin
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= TX;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`endif
        TX: begin
          if (last_sample) begin
            if (last_bit) begin
              bit_cnt <= '0;
              if (xfer) begin
                // Next word starts on the very next sample; phase is already aligned.
                shreg <= data_in;
              end else begin
                gen_en <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
module tb_bpsk_modulator;

  localparam int SN = 16;
  localparam int SW = 12;
  localparam int DW = 8;
`ifdef BPSK_PREAMBLE_EN
  localparam int PRE_LEN = DW * SN;
`else
  localparam int PRE_LEN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [SW-1:0] sin_in;
  logic [SW-1:0] neg_sin_in;
  logic [3:0]    cnt_in;
  logic          gen_en;
  logic [SW-1:0] mod_out;
  logic          mod_valid;
  logic          busy;

  always #5 clk = ~clk;

  bpsk_modulator #(
    .SAMPLE_NUMBER(SN),
    .SAMPLE_WIDTH (SW),
    .DATA_WIDTH   (DW),
    .PREAMBLE     (8'hAA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .sin_in    (sin_in),
    .neg_sin_in(neg_sin_in),
    .cnt_in    (cnt_in),
    .gen_en    (gen_en),
    .mod_out   (mod_out),
    .mod_valid (mod_valid),
    .busy      (busy)
  );

  // Behavioural generator: outputs sample of phase cnt-1, counter advances when enabled.
  function automatic logic [SW-1:0] sin_val(input int p);
    return SW'(p * 37 + 5);
  endfunction
  function automatic logic [SW-1:0] neg_val(input int p);
    return SW'(0) - sin_val(p);
  endfunction

  logic       gen_load;
  logic [3:0] gen_load_val;
  always @(posedge clk) begin
    if (gen_load) begin
      cnt_in <= gen_load_val;
    end else if (gen_en) begin
      sin_in     <= sin_val(int'(cnt_in));
      neg_sin_in <= neg_val(int'(cnt_in));
      cnt_in     <= cnt_in + 4'd1;
    end
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [SW-1:0] exp_q[$];

  task automatic push_word(input logic [DW-1:0] w);
    for (int b = DW - 1; b >= 0; b--)
      for (int p = 0; p < SN; p++)
        exp_q.push_back(w[b] ? sin_val(p) : neg_val(p));
  endtask

  task automatic push_frame_start();
`ifdef BPSK_PREAMBLE_EN
    push_word(8'hAA);
`endif
  endtask

  // Output monitor: scoreboard pop/compare plus run-length and handshake bookkeeping.
  int run_len = 0;
  int last_run = 0;
  int rdy_cnt = 0;
  int rdy_first = -1;
  int align_cycles = 0;
  logic [SW-1:0] exp_s;

  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
    end else begin
      if (mod_valid) begin
        run_len++;
        chk("sample_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_s = exp_q.pop_front();
          chk("sample", 32'(mod_out), 32'(exp_s));
        end
      end else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (busy && data_ready) begin
        if (rdy_cnt == 0) rdy_first = run_len;
        rdy_cnt++;
      end
      if (busy && gen_en && !mod_valid) align_cycles++;
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    data_in    = w;
    data_valid = 1'b1;
    #1;
    while (!data_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(data_ready), 32'd1);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || mod_valid || gen_en) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_gen_en", 32'(gen_en), 32'd0);
    chk("end_mod_valid", 32'(mod_valid), 32'd0);
  endtask

  task automatic clear_stats();
    rdy_cnt      = 0;
    rdy_first    = -1;
    align_cycles = 0;
    last_run     = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b0;
    data_valid   = 1'b0;
    data_in      = '0;
    gen_load     = 1'b1;
    gen_load_val = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_mod_out", 32'(mod_out), 32'd0);
    chk("rst_mod_valid", 32'(mod_valid), 32'd0);
    chk("rst_gen_en", 32'(gen_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    gen_load = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rel_data_ready", 32'(data_ready), 32'd1);
    chk("rel_gen_en", 32'(gen_en), 32'd0);
    chk("rel_mod_valid", 32'(mod_valid), 32'd0);

    // Single word, generator idle at phase 0 (worst-case alignment).
    clear_stats();
    push_frame_start();
    push_word(8'hA5);
    send(8'hA5);
    wait_idle();
    chk("a5_run_len", 32'(last_run), 32'(PRE_LEN + 128));
    chk("a5_q_empty", 32'(exp_q.size()), 32'd0);
    chk("a5_rdy_cnt", 32'(rdy_cnt), 32'd1);
    chk("a5_rdy_at", 32'(rdy_first), 32'(PRE_LEN + 127));
    chk("a5_align_le17", 32'(align_cycles <= 17 && align_cycles > 0), 32'd1);
    chk("a5_idle_ready", 32'(data_ready), 32'd1);

    // Back-to-back words, no preamble between them.
    clear_stats();
    push_frame_start();
    push_word(8'hFF);
    push_word(8'h00);
    send(8'hFF);
    send(8'h00);
    wait_idle();
    chk("b2b_run_len", 32'(last_run), 32'(PRE_LEN + 256));
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_rdy_cnt", 32'(rdy_cnt), 32'd2);
    chk("b2b_rdy_at", 32'(rdy_first), 32'(PRE_LEN + 127));

    // Alignment with the generator parked at phase 5.
    gen_load_val = 4'd5;
    gen_load     = 1'b1;
    @(negedge clk);
    gen_load = 1'b0;
    clear_stats();
    push_frame_start();
    push_word(8'hC3);
    send(8'hC3);
    wait_idle();
    chk("align_run_len", 32'(last_run), 32'(PRE_LEN + 128));
    chk("align_q_empty", 32'(exp_q.size()), 32'd0);
    chk("align_le17", 32'(align_cycles <= 17 && align_cycles > 0), 32'd1);

    // Reset in the middle of a frame at sample 40.
    clear_stats();
    push_frame_start();
    push_word(8'h5A);
    send(8'h5A);
    n = 0;
    while (run_len < 40 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_reached_40", 32'(run_len), 32'd40);
    rst = 1'b0;
    #1;
    chk("mid_rst_mod_valid", 32'(mod_valid), 32'd0);
    chk("mid_rst_gen_en", 32'(gen_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mod_out", 32'(mod_out), 32'd0);
    chk("mid_rst_data_ready", 32'(data_ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_data_ready", 32'(data_ready), 32'd1);
    chk("mid_rel_gen_en", 32'(gen_en), 32'd0);
    chk("mid_rel_mod_valid", 32'(mod_valid), 32'd0);

    clear_stats();
    push_frame_start();
    push_word(8'h80);
    send(8'h80);
    wait_idle();
    chk("post_run_len", 32'(last_run), 32'(PRE_LEN + 128));
    chk("post_q_empty", 32'(exp_q.size()), 32'd0);
    chk("post_rdy_cnt", 32'(rdy_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
